// File: rtl/filter_package.sv
// Shared constants and tap record for the channel-filter path.
// Used by the transition history and the downstream filter summer.
package filter_package;

  localparam int N_TAPS     = 4;
  localparam int TIME_WIDTH = 24;
  localparam int IN_WIDTH   = 16;
  localparam int IN_POINT   = 14;
  localparam int NL_W       = $clog2(N_TAPS + 1);

  localparam logic [IN_WIDTH-1:0] DT_MAX = 16'hFFFF;

  typedef struct packed {
    logic [TIME_WIDTH-1:0] stamp;
    logic                  dir;
    logic                  valid;
  } tap_t;

  function automatic logic [NL_W-1:0] popcount(
    input logic [N_TAPS-1:0] v
  );
    logic [NL_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      c = c + NL_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/time_hist_slot.sv
// One transition-history slot: shift-in, age, retire,
// and registered elapsed time for the pwl input.
module time_hist_slot
  import filter_package::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TIME_WIDTH-1:0] time_now_i,
  input  logic                  shift_i,
  input  tap_t                  prev_i,
  output tap_t                  tap_o,
  output logic                  valid_d_o,
  output logic [IN_WIDTH-1:0]   dt_o
);

  tap_t                  tap_q;
  tap_t                  tap_d;
  logic [IN_WIDTH-1:0]   dt_q;
  logic [IN_WIDTH-1:0]   dt_d;
  logic [TIME_WIDTH-1:0] diff;

  // Age is taken on whichever entry lands here, so a moved
  // entry is judged by its own pre-shift age.
  always_comb begin
    tap_d       = shift_i ? prev_i : tap_q;
    diff        = time_now_i - tap_d.stamp;
    tap_d.valid = tap_d.valid &&
                  (diff <= TIME_WIDTH'(DT_MAX));
    dt_d        = '0;
    if (tap_d.valid) begin
      dt_d = diff[IN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tap_q <= '0;
      dt_q  <= '0;
    end else begin
      tap_q <= tap_d;
      dt_q  <= dt_d;
    end
  end

  assign tap_o     = tap_q;
  assign valid_d_o = tap_d.valid;
  assign dt_o      = dt_q;

endmodule

// File: rtl/step_time_hist.sv
// History of recent symbol transitions, presenting per-tap
// elapsed time to the per-tap pwl step-response evaluators.
module step_time_hist
  import filter_package::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TIME_WIDTH-1:0]        time_now,
  input  logic                         symbol,
  input  logic                         sym_valid,
  output logic [N_TAPS*IN_WIDTH-1:0]   tap_dt,
  output logic [N_TAPS-1:0]            tap_dir,
  output logic [N_TAPS-1:0]            tap_valid,
  output logic [NL_W-1:0]              n_live
);

  logic            last_q;
  logic            push;
  logic [NL_W-1:0] n_live_q;
  logic [N_TAPS-1:0] valid_d;

  tap_t                taps [N_TAPS];
  tap_t                prev [N_TAPS];
  logic [IN_WIDTH-1:0] dt   [N_TAPS];
  tap_t                new_tap;

  assign push    = sym_valid && (symbol != last_q);
  assign new_tap = '{stamp: time_now, dir: symbol, valid: 1'b1};

  for (genvar k = 0; k < N_TAPS; k++) begin : g_slot
    if (k == 0) begin : g_head
      assign prev[k] = new_tap;
    end else begin : g_body
      assign prev[k] = taps[k-1];
    end

    time_hist_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .time_now_i (time_now),
      .shift_i    (push),
      .prev_i     (prev[k]),
      .tap_o      (taps[k]),
      .valid_d_o  (valid_d[k]),
      .dt_o       (dt[k])
    );

    assign tap_dt[k*IN_WIDTH +: IN_WIDTH] = dt[k];
    assign tap_dir[k]   = taps[k].dir;
    assign tap_valid[k] = taps[k].valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q   <= 1'b0;
      n_live_q <= '0;
    end else begin
      if (sym_valid) begin
        last_q <= symbol;
      end
      n_live_q <= popcount(valid_d);
    end
  end

  assign n_live = n_live_q;

endmodule

// File: tb/tb_step_time_hist.sv
// Directed bench for step_time_hist with a per-cycle
// transition-history model and hand-computed spot checks.
module tb_step_time_hist;

  logic        clk;
  logic        rst;
  logic [23:0] tnow;
  logic        symbol;
  logic        sym_valid;
  logic [63:0] tap_dt;
  logic [3:0]  tap_dir;
  logic [3:0]  tap_valid;
  logic [2:0]  n_live;

  int checks = 0;
  int errors = 0;

  step_time_hist dut (
    .clk       (clk),
    .rst       (rst),
    .time_now  (tnow),
    .symbol    (symbol),
    .sym_valid (sym_valid),
    .tap_dt    (tap_dt),
    .tap_dir   (tap_dir),
    .tap_valid (tap_valid),
    .n_live    (n_live)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Model: list of transitions, newest first, at most four kept.
  typedef struct {
    logic [23:0] t;
    bit          dir;
    bit          live;
  } tr_t;

  tr_t         hist [4];
  logic [23:0] mage [4];
  logic [15:0] e_dt [4];
  bit          m_last;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        hist[k] = '{24'h0, 1'b0, 1'b0};
        e_dt[k] = 16'h0;
      end
      m_last = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) mage[k] = tnow - hist[k].t;
      if (sym_valid && symbol != m_last) begin
        for (int k = 3; k > 0; k--) begin
          hist[k] = hist[k-1];
          mage[k] = mage[k-1];
        end
        hist[0] = '{tnow, symbol, 1'b1};
        mage[0] = 24'h0;
      end
      if (sym_valid) m_last = symbol;
      for (int k = 0; k < 4; k++) begin
        if (mage[k] > 24'h00FFFF) hist[k].live = 1'b0;
        e_dt[k] = hist[k].live ? mage[k][15:0] : 16'h0;
      end
    end
  end

  always @(posedge clk) begin
    logic [63:0] x_dt;
    logic [3:0]  x_dir;
    logic [3:0]  x_val;
    logic [2:0]  x_nl;
    #1;
    if (rst) begin
      x_dir = '0;
      x_val = '0;
      x_nl  = '0;
      for (int k = 0; k < 4; k++) begin
        x_dt[k*16 +: 16] = e_dt[k];
        x_dir[k] = hist[k].dir;
        x_val[k] = hist[k].live;
        x_nl     = x_nl + 3'(hist[k].live);
      end
      chk("cyc_tap_dt", tap_dt, x_dt);
      chk("cyc_tap_valid", {60'h0, tap_valid}, {60'h0, x_val});
      chk("cyc_tap_dir_live",
          {60'h0, tap_dir & x_val}, {60'h0, x_dir & x_val});
      chk("cyc_n_live", {61'h0, n_live}, {61'h0, x_nl});
    end
  end

  initial begin
    rst = 1'b0;
    tnow = '0;
    symbol = 1'b0;
    sym_valid = 1'b0;
    #1;
    chk("rst_valid", {60'h0, tap_valid}, 64'h0);
    chk("rst_dt", tap_dt, 64'h0);
    chk("rst_dir", {60'h0, tap_dir}, 64'h0);
    chk("rst_nlive", {61'h0, n_live}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // ramp with a steady low symbol: no pushes
    sym_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tnow = tnow + 24'd1;
    end
    @(negedge clk);
    chk("idle_valid", {60'h0, tap_valid}, 64'h0);
    chk("idle_nlive", {61'h0, n_live}, 64'h0);
    chk("idle_dt", tap_dt, 64'h0);

    // rising edge at t=100
    tnow = 24'd100;
    symbol = 1'b1;
    @(negedge clk);
    chk("push_valid", {60'h0, tap_valid}, 64'h1);
    chk("push_dir0", {63'h0, tap_dir[0]}, 64'h1);
    chk("push_dt0", {48'h0, tap_dt[15:0]}, 64'h0);
    sym_valid = 1'b0;
    tnow = 24'd101;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tnow = tnow + 24'd1;
    end
    @(negedge clk);
    chk("age10_dt0", {48'h0, tap_dt[15:0]}, 64'd10);

    // five alternating transitions at t=111..115
    sym_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tnow = 24'd111 + 24'(i);
      symbol = (i % 2 == 1);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    chk("full_valid", {60'h0, tap_valid}, 64'hF);
    chk("full_nlive", {61'h0, n_live}, 64'd4);
    chk("full_dir", {60'h0, tap_dir}, 64'hA);
    chk("full_dt", tap_dt, 64'h0003_0002_0001_0000);

    // rising edge just before wrap; old history retires
    tnow = 24'hFFFFF0;
    symbol = 1'b1;
    sym_valid = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tnow = tnow + 24'd1;
      @(negedge clk);
    end
    chk("wrap_dt0", {48'h0, tap_dt[15:0]}, 64'h20);
    chk("wrap_valid", {60'h0, tap_valid}, 64'h1);

    // two more pushes, then age the oldest to dt_max
    tnow = 24'h000100;
    symbol = 1'b0;
    sym_valid = 1'b1;
    @(negedge clk);
    tnow = 24'h000200;
    symbol = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    tnow = 24'h00FFEF;
    @(negedge clk);
    chk("max_valid", {60'h0, tap_valid}, 64'h7);
    chk("max_dt", tap_dt, 64'h0000_FFFF_FEEF_FDEF);
    tnow = 24'h00FFF0;
    @(negedge clk);
    chk("ret_valid", {60'h0, tap_valid}, 64'h3);
    chk("ret_dt", tap_dt, 64'h0000_0000_FEF0_FDF0);
    chk("ret_nlive", {61'h0, n_live}, 64'd2);

    // retire slot 1's entry on the same edge as a push
    tnow = 24'h0100FF;
    @(negedge clk);
    chk("pre_dt", tap_dt, 64'h0000_0000_FFFF_FEFF);
    tnow = 24'h010100;
    symbol = 1'b0;
    sym_valid = 1'b1;
    @(negedge clk);
    chk("pr_valid", {60'h0, tap_valid}, 64'h3);
    chk("pr_dir", {62'h0, tap_dir[1:0]}, 64'h2);
    chk("pr_dt", tap_dt, 64'h0000_0000_FF00_0000);
    chk("pr_nlive", {61'h0, n_live}, 64'd2);

    // third live tap, then asynchronous reset mid-cycle
    tnow = 24'h010101;
    symbol = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    chk("three_nlive", {61'h0, n_live}, 64'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", {60'h0, tap_valid}, 64'h0);
    chk("arst_dt", tap_dt, 64'h0);
    chk("arst_nlive", {61'h0, n_live}, 64'h0);
    chk("arst_dir", {60'h0, tap_dir}, 64'h0);
    sym_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("inrst_valid", {60'h0, tap_valid}, 64'h0);
    rst = 1'b1;
    tnow = 24'h000500;
    symbol = 1'b1;
    @(negedge clk);
    sym_valid = 1'b0;
    chk("post_valid", {60'h0, tap_valid}, 64'h1);
    chk("post_dir0", {63'h0, tap_dir[0]}, 64'h1);
    chk("post_dt0", {48'h0, tap_dt[15:0]}, 64'h0);
    tnow = 24'h000503;
    @(negedge clk);
    chk("post_age", {48'h0, tap_dt[15:0]}, 64'd3);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
